// File: rtl/calc_entry.sv
`default_nettype none
// ============================================================================
// Module  : calc_entry
// Brief   : Numpad key-event calculator with chained + - * / and a restoring divider.
// Revision: 1.0
// ============================================================================
module calc_entry #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] display,
  output logic             error,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_OP_SET  = 3'd1,
    S_ENTER_B = 3'd2,
    S_DIVIDE  = 3'd3,
    S_RESULT  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0]       c_OP_ADD = 2'd0;
  localparam logic [1:0]       c_OP_SUB = 2'd1;
  localparam logic [1:0]       c_OP_MUL = 2'd2;
  localparam logic [1:0]       c_OP_DIV = 2'd3;
  localparam logic [WIDTH-1:0] c_TEN    = WIDTH'(10);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt, r_a, w_a_nxt, r_result, w_result_nxt;
  logic [WIDTH-1:0] r_display, w_display_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt, r_quo, w_quo_nxt, r_dvs, w_dvs_nxt;
  logic [1:0]       r_op, w_op_nxt, r_pend_op, w_pend_op_nxt;
  logic             r_pend_valid, w_pend_valid_nxt, r_neg, w_neg_nxt;
  logic             r_error, r_busy;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [IW-1:0]    r_iter, w_iter_nxt;

  // Key decode: bit 4 marks a real event, low nibble is the key index
  logic             w_event, w_clr, w_eq, w_oper, w_dig;
  logic [3:0]       w_k;
  logic [WIDTH-1:0] w_digit;

  assign w_event = key_code[4];
  assign w_k     = key_code[3:0];
  assign w_clr   = w_event && (w_k == 4'd7);
  assign w_eq    = w_event && (w_k == 4'd11);
  assign w_oper  = w_event && (w_k[3:2] == 2'b11);

  always_comb begin
    w_dig   = w_event;
    w_digit = '0;
    case (w_k)
      4'd3:    w_digit = WIDTH'(0);
      4'd0:    w_digit = WIDTH'(1);
      4'd4:    w_digit = WIDTH'(2);
      4'd8:    w_digit = WIDTH'(3);
      4'd1:    w_digit = WIDTH'(4);
      4'd5:    w_digit = WIDTH'(5);
      4'd9:    w_digit = WIDTH'(6);
      4'd2:    w_digit = WIDTH'(7);
      4'd6:    w_digit = WIDTH'(8);
      4'd10:   w_digit = WIDTH'(9);
      default: w_dig   = 1'b0;
    endcase
  end

  // Digit accumulation; a zero onto an empty operand does not consume a slot
  logic             w_room;
  logic [WIDTH-1:0] w_dig_acc;
  logic [CW-1:0]    w_dig_cnt, w_first_cnt;

  assign w_room      = r_count < CW'(MAX_DIGITS);
  assign w_dig_acc   = r_acc * c_TEN + w_digit;
  assign w_dig_cnt   = (w_digit == '0 && r_acc == '0) ? r_count : r_count + CW'(1);
  assign w_first_cnt = (w_digit == '0) ? '0 : CW'(1);

  // Exact double-width evaluation so overflow is detected, not wrapped
  logic signed [2*WIDTH-1:0] w_ax, w_bx, w_exact;
  logic                      w_ovf;

  assign w_ax = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_bx = {{WIDTH{r_acc[WIDTH-1]}}, r_acc};

  always_comb begin
    case (r_op)
      c_OP_SUB: w_exact = w_ax - w_bx;
      c_OP_MUL: w_exact = w_ax * w_bx;
      default:  w_exact = w_ax + w_bx;
    endcase
  end

  assign w_ovf = (w_exact[2*WIDTH-1:WIDTH-1] != '0) && (w_exact[2*WIDTH-1:WIDTH-1] != '1);

  // One restoring step per cycle on magnitudes; dividend shifts out of r_quo
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_q, w_sq, w_rem_step;
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_qbit;

  assign w_mag_a    = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_mag_b    = r_acc[WIDTH-1] ? -r_acc : r_acc;
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_q        = {r_quo[WIDTH-2:0], w_qbit};
  assign w_rem_step = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_sq       = r_neg ? -w_q : w_q;

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_a_nxt          = r_a;
    w_result_nxt     = r_result;
    w_op_nxt         = r_op;
    w_pend_op_nxt    = r_pend_op;
    w_pend_valid_nxt = r_pend_valid;
    w_count_nxt      = r_count;
    w_rem_nxt        = r_rem;
    w_quo_nxt        = r_quo;
    w_dvs_nxt        = r_dvs;
    w_neg_nxt        = r_neg;
    w_iter_nxt       = r_iter;
    w_display_nxt    = '0;

    if (w_clr) begin
      w_state_nxt      = S_ENTER_A;
      w_acc_nxt        = '0;
      w_a_nxt          = '0;
      w_result_nxt     = '0;
      w_op_nxt         = c_OP_ADD;
      w_pend_valid_nxt = 1'b0;
      w_count_nxt      = '0;
    end else begin
      case (r_state)
        S_ENTER_A, S_ENTER_B: begin
          if (w_dig) begin
            if (w_room) begin
              w_acc_nxt   = w_dig_acc;
              w_count_nxt = w_dig_cnt;
            end
          end else if (w_oper && r_state == S_ENTER_A) begin
            w_a_nxt     = r_acc;
            w_op_nxt    = w_k[1:0];
            w_state_nxt = S_OP_SET;
          end else if ((w_oper || w_eq) && r_state == S_ENTER_B) begin
            if (r_op == c_OP_DIV) begin
              if (r_acc == '0) begin
                w_state_nxt = S_ERROR;
              end else begin
                w_rem_nxt        = '0;
                w_quo_nxt        = w_mag_a;
                w_dvs_nxt        = w_mag_b;
                w_neg_nxt        = r_a[WIDTH-1] ^ r_acc[WIDTH-1];
                w_iter_nxt       = '0;
                w_pend_valid_nxt = w_oper;
                w_pend_op_nxt    = w_k[1:0];
                w_state_nxt      = S_DIVIDE;
              end
            end else if (w_ovf) begin
              w_state_nxt = S_ERROR;
            end else if (w_oper) begin
              w_a_nxt     = w_exact[WIDTH-1:0];
              w_op_nxt    = w_k[1:0];
              w_state_nxt = S_OP_SET;
            end else begin
              w_result_nxt = w_exact[WIDTH-1:0];
              w_state_nxt  = S_RESULT;
            end
          end
        end
        S_OP_SET: begin
          if (w_oper) begin
            w_op_nxt = w_k[1:0];
          end else if (w_dig) begin
            w_acc_nxt   = w_digit;
            w_count_nxt = w_first_cnt;
            w_state_nxt = S_ENTER_B;
          end
        end
        S_DIVIDE: begin
          w_rem_nxt  = w_rem_step;
          w_quo_nxt  = w_q;
          w_iter_nxt = r_iter + IW'(1);
          if (r_iter == IW'(WIDTH - 1)) begin
            if (!r_neg && w_q[WIDTH-1]) begin
              w_state_nxt = S_ERROR;
            end else if (r_pend_valid) begin
              w_a_nxt     = w_sq;
              w_op_nxt    = r_pend_op;
              w_state_nxt = S_OP_SET;
            end else begin
              w_result_nxt = w_sq;
              w_state_nxt  = S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (w_dig) begin
            w_acc_nxt   = w_digit;
            w_count_nxt = w_first_cnt;
            w_state_nxt = S_ENTER_A;
          end else if (w_oper) begin
            w_a_nxt     = r_result;
            w_op_nxt    = w_k[1:0];
            w_state_nxt = S_OP_SET;
          end
        end
        S_ERROR: ;
        default: w_state_nxt = S_ENTER_A;
      endcase
    end

    case (w_state_nxt)
      S_ENTER_A, S_ENTER_B: w_display_nxt = w_acc_nxt;
      S_OP_SET, S_DIVIDE:   w_display_nxt = w_a_nxt;
      S_RESULT:             w_display_nxt = w_result_nxt;
      default:              w_display_nxt = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_ENTER_A;
      r_acc        <= '0;
      r_a          <= '0;
      r_result     <= '0;
      r_op         <= c_OP_ADD;
      r_pend_op    <= c_OP_ADD;
      r_pend_valid <= 1'b0;
      r_count      <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvs        <= '0;
      r_neg        <= 1'b0;
      r_iter       <= '0;
      r_display    <= '0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_a          <= w_a_nxt;
      r_result     <= w_result_nxt;
      r_op         <= w_op_nxt;
      r_pend_op    <= w_pend_op_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_count      <= w_count_nxt;
      r_rem        <= w_rem_nxt;
      r_quo        <= w_quo_nxt;
      r_dvs        <= w_dvs_nxt;
      r_neg        <= w_neg_nxt;
      r_iter       <= w_iter_nxt;
      r_display    <= w_display_nxt;
      r_error      <= (w_state_nxt == S_ERROR);
      r_busy       <= (w_state_nxt == S_DIVIDE);
    end
  end

  assign display = r_display;
  assign error   = r_error;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: doc/calc_entry.md
Name: calc_entry

Overview:
Key-event consumer placed directly downstream of the numpad scanner. It takes the scanner's 5-bit one-cycle key event and builds decimal operands. It applies + - * / with left-to-right chaining and drives a signed binary result to the display stage. Division is a multi-cycle restoring divider; every other operation completes in one cycle.

Parameters:
WIDTH, 16, operand/result width, two's complement
MAX_DIGITS, 4, maximum decimal digits per entered operand

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
key_code  input  5  scanner event: 0 = none; 16+k = key index k (0..15) pressed, valid for exactly one cycle
display  output  WIDTH  signed value to show
error  output  1  overflow or divide-by-zero latched
busy  output  1  divider running

Behaviour:
- Event when key_code[4]==1, with index k=key_code[3:0]. Codes 1..15 are ignored.
- Digit map, index->digit: 3->0, 0->1, 4->2, 8->3, 1->4, 5->5, 9->6, 2->7, 6->8, 10->9.
- Operator map: 12 '+', 13 '-', 14 '*', 15 '/', 11 '=', 7 CLR.
- Registers: acc, a (signed WIDTH), op (2 bits), pend_op, digit count.
- States: ENTER_A, OP_SET, ENTER_B, DIVIDE, RESULT, ERROR.
- Reset: state ENTER_A; acc=a=display=0; op=+; count=0; error=0; busy=0. Reset overrides everything, including mid-divide.
- Digit entry (ENTER_A/ENTER_B):
  - If count<MAX_DIGITS: acc=acc*10+d, count++.
  - Exception: d=0 with acc==0 leaves count 0, so leading zeros are not counted.
  - At the limit, digits are ignored.
- ENTER_A:
  - Operator: a<=acc, op<=key, goto OP_SET.
  - '=': ignored.
- OP_SET:
  - Operator: replaces op.
  - Digit: acc=d, count per digit rule, goto ENTER_B.
  - '=': ignored.
- ENTER_B:
  - '=': evaluate a op acc.
  - Operator: evaluate the same way, then the result becomes a, the new operator becomes op, goto OP_SET. For '/' the new operator is held in pend_op until the divide completes.
- RESULT:
  - Digit: acc=d, goto ENTER_A.
  - Operator: a<=result, goto OP_SET.
  - '=': ignored.
- Evaluation:
  - + - * use exact 2*WIDTH signed arithmetic.
  - If the exact result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], goto ERROR.
  - Otherwise the result is registered and display updates on the cycle after the key event.
- Divide:
  - Divisor 0: ERROR on the cycle after the event.
  - Otherwise enter DIVIDE with busy=1 for exactly WIDTH cycles. The divider is unsigned restoring on magnitudes; the sign is applied after, and the quotient truncates toward zero.
  - Result appears and busy drops on cycle WIDTH+1 after the event.
  - The -2^(WIDTH-1)/-1 case overflows and goes to ERROR.
- While busy, all key events except CLR are dropped.
- CLR in any state, including DIVIDE: same as reset, effective next cycle, and aborts the divide.
- ERROR: error=1, display=0. All keys except CLR are ignored.
- Display source by state:
  - ENTER_A/ENTER_B: acc.
  - OP_SET: a.
  - RESULT: result.
  - DIVIDE: held at a.
  - ERROR: 0.
- display is registered.

Test Plan:
- Key codes 16,20,28,24,17,27 ("12+34=") -> display 1,12,12,3,34,46; error=0.
- Codes 21,29,26,27 ("5-9=") -> display 0xFFFC (-4).
- Codes 16,20,24,17,21 ("12345") -> display 1234 and fifth digit ignored; leading "0,0,7" (19,19,18) -> 7 with count 1.
- "9999*9999=" -> error=1, display 0; digit 16 ignored; CLR (23) -> error=0, display 0, state ENTER_A.
- "100/7=" -> busy high exactly 16 cycles, display 14 on cycle 17; digit injected mid-divide dropped. "1/0=" -> error on next cycle. Reset asserted mid-divide -> busy=0, display 0.
- Chain "2+3*4=" (20,28,24,30,17,27) -> display 5 after '*', final 20; codes 1..15 injected throughout have no effect.
